// File: rtl/bubsys_mixer_pkg.sv
// Shared constants and layer codes for the bubsys tilemap/object layer mixer.
package bubsys_mixer_pkg;

  localparam int ATTR_W        = 7;
  localparam int PIX_W         = 4;
  localparam int PRI_BIT       = 6;
  localparam int COLOR_MSB     = 5;
  localparam int CD_W          = 11;
  localparam int A_LATENCY_DEF = 4;
  localparam int B_LATENCY_DEF = 1;

  localparam logic [1:0] MODE_LOAD = 2'b11;

  typedef enum logic [1:0] {
    LAYER_BD  = 2'd0,
    LAYER_A   = 2'd1,
    LAYER_B   = 2'd2,
    LAYER_OBJ = 2'd3
  } layer_e;

endpackage

// File: rtl/bubsys_attr_delay.sv
// Tile attribute delay: load-flag pipe, attribute pipe and current-attribute hold
// register, so a tile's attribute lines up with its first pixel DEPTH enables after load.
module bubsys_attr_delay
  import bubsys_mixer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              load,
  input  logic [ATTR_W-1:0] attr_in,
  output logic [ATTR_W-1:0] attr_out
);

  logic [DEPTH-1:0]  flag_q, flag_d;
  logic [ATTR_W-1:0] pipe_q [DEPTH];
  logic [ATTR_W-1:0] pipe_d [DEPTH];
  logic [ATTR_W-1:0] cur_q, cur_d;

  always_comb begin
    flag_d = flag_q;
    pipe_d = pipe_q;
    cur_d  = cur_q;
    if (en) begin
      flag_d[0] = load;
      pipe_d[0] = attr_in;
      for (int i = 1; i < DEPTH; i++) begin
        flag_d[i] = flag_q[i-1];
        pipe_d[i] = pipe_q[i-1];
      end
      if (flag_q[DEPTH-1]) cur_d = pipe_q[DEPTH-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flag_q <= '0;
      cur_q  <= '0;
      for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
    end else begin
      flag_q <= flag_d;
      cur_q  <= cur_d;
      pipe_q <= pipe_d;
    end
  end

  // The exiting attribute is already current on the enable its flag sits in the last stage.
  assign attr_out = flag_q[DEPTH-1] ? pipe_q[DEPTH-1] : cur_q;

endmodule

// File: rtl/bubsys_layer_mixer.sv
// TM-A / TM-B / object priority mixer producing a registered palette address.
// Optional BUBSYS_MIXER_LAYER_MASK_EN adds i_LAYER_EN to force layers transparent.
module bubsys_layer_mixer
  import bubsys_mixer_pkg::*;
#(
  parameter int A_LATENCY = A_LATENCY_DEF,
  parameter int B_LATENCY = B_LATENCY_DEF
) (
  input  logic              i_EMU_MCLK,
  input  logic              i_EMU_RST,
  input  logic              i_EMU_CLK6MPCEN_n,
  input  logic [1:0]        i_A_MODE,
  input  logic [1:0]        i_B_MODE,
  input  logic [ATTR_W-1:0] i_A_ATTR,
  input  logic [ATTR_W-1:0] i_B_ATTR,
  input  logic [PIX_W-1:0]  i_A_PIXEL,
  input  logic [PIX_W-1:0]  i_B_PIXEL,
  input  logic              i_A_TRN_n,
  input  logic              i_B_TRN_n,
  input  logic [PIX_W-1:0]  i_OBJ_PIXEL,
  input  logic [5:0]        i_OBJ_COLOR,
  input  logic              i_OBJ_PRI,
  input  logic              i_BLANK,
  output logic [CD_W-1:0]   o_CD,
  output logic [1:0]        o_LAYER
`ifdef BUBSYS_MIXER_LAYER_MASK_EN
  , input logic [2:0]       i_LAYER_EN
`endif
);

  logic              en;
  logic [2:0]        layer_en;
  logic [ATTR_W-1:0] attr_a, attr_b;
  logic              a_op, b_op, obj_op;
  layer_e            win;
  logic [CD_W-1:0]   cd_q, cd_d;
  layer_e            layer_q, layer_d;
  logic              unused_a_pri;

  assign en = ~i_EMU_CLK6MPCEN_n;

`ifdef BUBSYS_MIXER_LAYER_MASK_EN
  assign layer_en = i_LAYER_EN;
`else
  assign layer_en = 3'b111;
`endif

  bubsys_attr_delay #(.DEPTH(A_LATENCY)) u_attr_a (
    .clk      (i_EMU_MCLK),
    .rst      (i_EMU_RST),
    .en       (en),
    .load     (i_A_MODE == MODE_LOAD),
    .attr_in  (i_A_ATTR),
    .attr_out (attr_a)
  );

  bubsys_attr_delay #(.DEPTH(B_LATENCY)) u_attr_b (
    .clk      (i_EMU_MCLK),
    .rst      (i_EMU_RST),
    .en       (en),
    .load     (i_B_MODE == MODE_LOAD),
    .attr_in  (i_B_ATTR),
    .attr_out (attr_b)
  );

  // Only TM-B's priority bit reorders the tilemaps; TM-A's is carried but ignored.
  assign unused_a_pri = attr_a[PRI_BIT];

  assign a_op   = i_A_TRN_n & layer_en[0];
  assign b_op   = i_B_TRN_n & layer_en[1];
  assign obj_op = (i_OBJ_PIXEL != '0) & layer_en[2];

  always_comb begin
    win = LAYER_BD;
    if (i_BLANK)                      win = LAYER_BD;
    else if (obj_op && i_OBJ_PRI)     win = LAYER_OBJ;
    else if (attr_b[PRI_BIT] && b_op) win = LAYER_B;
    else if (a_op)                    win = LAYER_A;
    else if (b_op)                    win = LAYER_B;
    else if (obj_op)                  win = LAYER_OBJ;
  end

  always_comb begin
    cd_d    = cd_q;
    layer_d = layer_q;
    if (en) begin
      layer_d = win;
      case (win)
        LAYER_A:   cd_d = {1'b0, attr_a[COLOR_MSB:0], i_A_PIXEL};
        LAYER_B:   cd_d = {1'b0, attr_b[COLOR_MSB:0], i_B_PIXEL};
        LAYER_OBJ: cd_d = {1'b1, i_OBJ_COLOR, i_OBJ_PIXEL};
        default:   cd_d = '0;
      endcase
    end
  end

  always_ff @(posedge i_EMU_MCLK) begin
    if (i_EMU_RST) begin
      cd_q    <= '0;
      layer_q <= LAYER_BD;
    end else begin
      cd_q    <= cd_d;
      layer_q <= layer_d;
    end
  end

  assign o_CD    = cd_q;
  assign o_LAYER = layer_q;

endmodule

// File: tb/tb_bubsys_layer_mixer.sv
// Self-checking bench for bubsys_layer_mixer: directed scenarios plus randomized
// traffic against an enable-indexed behavioural model (honours BUBSYS_MIXER_LAYER_MASK_EN).
module tb_bubsys_layer_mixer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en_n = 1'b1;
  logic [1:0]  a_mode = '0, b_mode = '0;
  logic [6:0]  a_attr = '0, b_attr = '0;
  logic [3:0]  a_pix = '0, b_pix = '0;
  logic        a_trn = 1'b0, b_trn = 1'b0;
  logic [3:0]  obj_pix = '0;
  logic [5:0]  obj_col = '0;
  logic        obj_pri = 1'b0;
  logic        blank = 1'b0;
  logic [2:0]  layer_en = 3'b111;
  logic [10:0] o_cd;
  logic [1:0]  o_layer;

  int checks = 0;
  int failures = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  bubsys_layer_mixer dut (
    .i_EMU_MCLK        (clk),
    .i_EMU_RST         (rst),
    .i_EMU_CLK6MPCEN_n (en_n),
    .i_A_MODE          (a_mode),
    .i_B_MODE          (b_mode),
    .i_A_ATTR          (a_attr),
    .i_B_ATTR          (b_attr),
    .i_A_PIXEL         (a_pix),
    .i_B_PIXEL         (b_pix),
    .i_A_TRN_n         (a_trn),
    .i_B_TRN_n         (b_trn),
    .i_OBJ_PIXEL       (obj_pix),
    .i_OBJ_COLOR       (obj_col),
    .i_OBJ_PRI         (obj_pri),
    .i_BLANK           (blank),
    .o_CD              (o_cd),
    .o_LAYER           (o_layer)
`ifdef BUBSYS_MIXER_LAYER_MASK_EN
    , .i_LAYER_EN      (layer_en)
`endif
  );

  // Behavioural model: pending loads are kept with the enable number at which they become current.
  typedef struct {
    int unsigned arrive;
    logic [6:0]  attr;
  } ld_t;

  ld_t         qa[$];
  ld_t         qb[$];
  int unsigned m_cnt = 0;
  logic [6:0]  m_cur_a = '0, m_cur_b = '0;
  logic [10:0] m_cd = '0;
  logic [1:0]  m_layer = '0;

  always @(posedge clk) begin
    logic [2:0] msk;
    logic ao, bo, oo;
`ifdef BUBSYS_MIXER_LAYER_MASK_EN
    msk = layer_en;
`else
    msk = 3'b111;
`endif
    if (rst) begin
      qa.delete();
      qb.delete();
      m_cur_a = '0;
      m_cur_b = '0;
      m_cd    = '0;
      m_layer = 2'd0;
    end else if (!en_n) begin
      m_cnt++;
      while (qa.size() > 0 && qa[0].arrive <= m_cnt) begin m_cur_a = qa[0].attr; qa.delete(0); end
      while (qb.size() > 0 && qb[0].arrive <= m_cnt) begin m_cur_b = qb[0].attr; qb.delete(0); end
      ao = a_trn & msk[0];
      bo = b_trn & msk[1];
      oo = (obj_pix != 0) & msk[2];
      if (blank)                    begin m_cd = 0; m_layer = 0; end
      else if (oo && obj_pri)       begin m_cd = {1'b1, obj_col, obj_pix}; m_layer = 3; end
      else if (m_cur_b[6] && bo)    begin m_cd = {1'b0, m_cur_b[5:0], b_pix}; m_layer = 2; end
      else if (ao)                  begin m_cd = {1'b0, m_cur_a[5:0], a_pix}; m_layer = 1; end
      else if (bo)                  begin m_cd = {1'b0, m_cur_b[5:0], b_pix}; m_layer = 2; end
      else if (oo)                  begin m_cd = {1'b1, obj_col, obj_pix}; m_layer = 3; end
      else                          begin m_cd = 0; m_layer = 0; end
      if (a_mode == 2'b11) qa.push_back('{m_cnt + 4, a_attr});
      if (b_mode == 2'b11) qb.push_back('{m_cnt + 1, b_attr});
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      checks++;
      if (o_cd !== m_cd || o_layer !== m_layer) begin
        failures++;
        $display("FAIL model_cmp t=%0t cd=%h exp_cd=%h layer=%0d exp_layer=%0d",
                 $time, o_cd, m_cd, o_layer, m_layer);
      end
    end
  end

  task automatic chk(input string nm, input logic [10:0] got, input logic [10:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", nm, got, exp);
    end
  endtask

  // One pixel enable, then a few idle clocks with load modes and pixels scrambled
  // (they must be ignored while the enable is inactive).
  task automatic do_en();
    logic [1:0] sam, sbm;
    logic [3:0] sap, sbp;
    en_n = 1'b0;
    @(posedge clk); #1;
    en_n = 1'b1;
    sam = a_mode; sbm = b_mode; sap = a_pix; sbp = b_pix;
    repeat ($urandom_range(0, 2)) begin
      a_mode = 2'b11; b_mode = 2'b11;
      a_pix = 4'($urandom); b_pix = 4'($urandom);
      @(posedge clk); #1;
    end
    a_mode = sam; b_mode = sbm; a_pix = sap; b_pix = sbp;
  endtask

  task automatic pulse_rst();
    en_n = 1'b1;
    rst  = 1'b1;
    @(posedge clk); #1;
    rst  = 1'b0;
  endtask

  task automatic clear_inputs();
    a_mode = 0; b_mode = 0; a_attr = 0; b_attr = 0;
    a_pix = 0; b_pix = 0; a_trn = 0; b_trn = 0;
    obj_pix = 0; obj_col = 0; obj_pri = 0; blank = 0; layer_en = 3'b111;
  endtask

  task automatic run_b_case(input logic [6:0] battr, input logic [10:0] exp_cd,
                            input logic [1:0] exp_layer, input string nm);
    clear_inputs();
    pulse_rst();
    for (int i = 1; i <= 11; i++) begin
      b_mode = (i == 10) ? 2'b11 : 2'b00;
      b_attr = (i == 10) ? battr : 7'h00;
      if (i >= 10) begin a_pix = 4'h1; a_trn = 1; b_pix = 4'h2; b_trn = 1; end
      do_en();
      if (i == 10) chk({nm, "_before_cd"}, o_cd, 11'h001);
      if (i == 11) begin
        chk({nm, "_cd"}, o_cd, exp_cd);
        chk({nm, "_layer"}, {9'd0, o_layer}, {9'd0, exp_layer});
      end
    end
    b_mode = 2'b00;
  endtask

  initial begin
    int pa, pb;
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_on = 1'b1;
    chk("reset_cd", o_cd, 11'h000);
    chk("reset_layer", {9'd0, o_layer}, 11'd0);

    // TM-A load at enable 10, opaque pixel from 14
    for (int i = 1; i <= 15; i++) begin
      a_mode = (i == 10) ? 2'b11 : 2'b00;
      a_attr = (i == 10) ? 7'h15 : 7'h00;
      a_pix  = (i >= 14) ? 4'h3 : 4'h0;
      a_trn  = (i >= 14);
      do_en();
      if (i == 13) chk("a_pre_cd", o_cd, 11'h000);
      if (i == 14) begin
        chk("a_load_cd", o_cd, 11'h153);
        chk("a_load_layer", {9'd0, o_layer}, 11'd1);
      end
    end

    run_b_case(7'h40, 11'h002, 2'd2, "b_pri");
    run_b_case(7'h00, 11'h001, 2'd1, "b_nopri");

    obj_pix = 4'h5; obj_col = 6'h3F; obj_pri = 1;
    do_en();
    chk("obj_pri_cd", o_cd, 11'h7F5);
    chk("obj_pri_layer", {9'd0, o_layer}, 11'd3);
    obj_pri = 0;
    do_en();
    chk("obj_low_a_cd", o_cd, 11'h001);
    a_trn = 0; a_pix = 0; b_trn = 0; b_pix = 0;
    do_en();
    chk("obj_low_cd", o_cd, 11'h7F5);
    chk("obj_low_layer", {9'd0, o_layer}, 11'd3);
    obj_pix = 0;
    do_en();
    chk("all_trn_cd", o_cd, 11'h000);
    chk("all_trn_layer", {9'd0, o_layer}, 11'd0);
    obj_pix = 4'h5; obj_pri = 1; blank = 1;
    do_en();
    chk("blank_cd", o_cd, 11'h000);
    chk("blank_layer", {9'd0, o_layer}, 11'd0);
    blank = 0;

`ifdef BUBSYS_MIXER_LAYER_MASK_EN
    obj_pix = 0; obj_pri = 0;
    a_pix = 4'h1; a_trn = 1; b_pix = 4'h2; b_trn = 1;
    layer_en = 3'b110;
    do_en();
    chk("mask_cd", o_cd, 11'h002);
    chk("mask_layer", {9'd0, o_layer}, 11'd2);
    layer_en = 3'b111;
`endif

    // Reset two enables after a TM-A load discards it; the next load restores colour.
    clear_inputs();
    pulse_rst();
    for (int i = 1; i <= 22; i++) begin
      a_mode = (i == 10 || i == 18) ? 2'b11 : 2'b00;
      a_attr = (i == 10 || i == 18) ? 7'h15 : 7'h00;
      a_pix = 4'h3; a_trn = 1;
      do_en();
      if (i == 12) pulse_rst();
      if (i == 14) chk("rst_drop_cd", o_cd, 11'h003);
      if (i == 21) chk("rst_prev_cd", o_cd, 11'h003);
      if (i == 22) chk("rst_reload_cd", o_cd, 11'h153);
    end

    // Randomized traffic: one load per layer every 8 enables at independent phases.
    clear_inputs();
    pa = $urandom_range(0, 7);
    pb = $urandom_range(0, 7);
    for (int n = 0; n < 3000; n++) begin
      a_mode  = (n % 8 == pa) ? 2'b11 : 2'($urandom_range(0, 2));
      b_mode  = (n % 8 == pb) ? 2'b11 : 2'($urandom_range(0, 2));
      a_attr  = 7'($urandom);
      b_attr  = 7'($urandom);
      a_pix   = 4'($urandom);
      b_pix   = 4'($urandom);
      a_trn   = 1'($urandom);
      b_trn   = 1'($urandom);
      obj_pix = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      obj_col = 6'($urandom);
      obj_pri = 1'($urandom);
      blank   = ($urandom_range(0, 9) == 0);
`ifdef BUBSYS_MIXER_LAYER_MASK_EN
      layer_en = 3'($urandom);
`endif
      do_en();
      if ($urandom_range(0, 299) == 0) pulse_rst();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
